imem_dmem_arbiter: RTL

Shares one single-port synchronous-read SRAM between the fetch stage (instruction reads) and the memory stage (data loads/stores). Data requests have fixed priority, with a starvation guard that forces a fetch grant after a bounded wait. The arbiter issues at most one SRAM access per cycle, tracks which requester owns the read data arriving one cycle later, and routes that data back. It sits between the fetch/memory stages and the SRAM macro, replacing their separate ROM/RAM ports.

---
 rtl/imem_dmem_arbiter_if.sv | 29 ++
 rtl/imem_dmem_arbiter.sv | 40 ++++
 2 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: fetch, data and SRAM bus signals shared through the imem/dmem arbiter
interface imem_dmem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_cancel;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [3:0]  dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  modport master (
    output if_req, if_addr, if_cancel, dm_req, dm_wen, dm_addr, dm_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, ram_en, ram_wen, ram_addr, ram_wdata
  );
  modport slave (
    input  if_req, if_addr, if_cancel, dm_req, dm_wen, dm_addr, dm_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one sync-read SRAM between fetch and data, data first with a fetch starvation guard
module imem_dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic resetn,
  imem_dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {NONE, OWN_IF, OWN_DM} owner_t;
  owner_t     resp_owner;
  logic [2:0] starve_cnt;
  logic       if_live;
  logic       if_first;
  assign if_live  = bus.if_req & ~bus.if_cancel;
  assign if_first = if_live & (starve_cnt == 3'(STARVE_LIMIT));
  assign bus.if_gnt = resetn & if_live & (if_first | ~bus.dm_req);
  assign bus.dm_gnt = resetn & bus.dm_req & ~if_first;
  // rvalid is also gated by reset so a response pending at reset is dropped at once
  assign bus.if_rvalid = resetn & (resp_owner == OWN_IF) & ~bus.if_cancel;
  assign bus.dm_rvalid = resetn & (resp_owner == OWN_DM);
  assign bus.if_rdata  = bus.ram_rdata;
  assign bus.dm_rdata  = bus.ram_rdata;
  always_comb begin
    bus.ram_en    = bus.if_gnt | bus.dm_gnt;
    bus.ram_wen   = bus.dm_gnt ? bus.dm_wen : 4'b0000;
    bus.ram_addr  = bus.if_gnt ? bus.if_addr : bus.dm_gnt ? bus.dm_addr : 32'h0;
    bus.ram_wdata = bus.dm_gnt ? bus.dm_wdata : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
      resp_owner <= NONE;
    end else begin
      starve_cnt <= (!if_live || bus.if_gnt) ? 3'd0 :
                    (starve_cnt == 3'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 3'd1;
      resp_owner <= bus.if_gnt ? OWN_IF :
                    (bus.dm_gnt && bus.dm_wen == 4'b0000) ? OWN_DM : NONE;
    end
  end
endmodule
